regfile_wb_queue: RTL

REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

---
 rtl/regfile_pkg.sv | 13 +
 rtl/wbq_match.sv | 30 +++
 rtl/regfile_wb_queue.sv | 74 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and the queue entry type for the register-file writeback path.
package regfile_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int WBQ_DEPTH  = 4;
   localparam int PTR_W      = 2;
   localparam int CNT_W      = 3;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;
endpackage

// File: rtl/wbq_match.sv
// Youngest-match search over the valid queue entries for decode-stage bypass.
module wbq_match
   import regfile_pkg::*;
(
   input  wb_entry_t [WBQ_DEPTH-1:0] entries,
   input  logic [PTR_W-1:0]          rd_ptr,
   input  logic [CNT_W-1:0]          count,
   input  logic [REG_ADDR_W-1:0]     lookup_reg,
   output logic                      hit,
   output logic [DATA_W-1:0]         data
);

   logic [PTR_W-1:0] idx;

   // Walk oldest to youngest so the last match seen is the youngest one.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = 0; k < WBQ_DEPTH; k++) begin
         idx = rd_ptr + PTR_W'(k);
         if ((CNT_W'(k) < count) && (lookup_reg != '0) &&
             (entries[idx].addr == lookup_reg)) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_queue.sv
// 4-entry in-order writeback FIFO feeding the single register-file write port.
// Define REGFILE_WB_QUEUE_BYPASS_EN to build the pending-write lookup; otherwise lookup_* read 0.
module regfile_wb_queue
   import regfile_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [REG_ADDR_W-1:0] in_reg,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  wr_hold,
   output logic                  wr_en,
   output logic [REG_ADDR_W-1:0] wr_reg,
   output logic [DATA_W-1:0]     wr_data,
   input  logic [REG_ADDR_W-1:0] lookup_reg,
   output logic                  lookup_hit,
   output logic [DATA_W-1:0]     lookup_data,
   output logic [CNT_W-1:0]      count
);

   wb_entry_t [WBQ_DEPTH-1:0] mem;
   wb_entry_t                 head;
   logic [PTR_W-1:0]          wr_ptr;
   logic [PTR_W-1:0]          rd_ptr;
   logic [CNT_W-1:0]          cnt_q;
   logic                      push;
   logic                      pop;

   assign count    = cnt_q;
   assign in_ready = (cnt_q < CNT_W'(WBQ_DEPTH));
   assign wr_en    = (cnt_q != '0) && !wr_hold;
   assign head     = mem[rd_ptr];
   assign wr_reg   = wr_en ? head.addr : '0;
   assign wr_data  = wr_en ? head.data : '0;

   // Writes to r0 are architecturally discarded, so they are accepted but never queued.
   assign push = in_valid && in_ready && (in_reg != '0);
   assign pop  = wr_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage is left unreset; validity comes only from the pointers and count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{addr: in_reg, data: in_data};
   end

`ifdef REGFILE_WB_QUEUE_BYPASS_EN
   wbq_match u_match (
      .entries    (mem),
      .rd_ptr     (rd_ptr),
      .count      (cnt_q),
      .lookup_reg (lookup_reg),
      .hit        (lookup_hit),
      .data       (lookup_data)
   );
`else
   logic unused_lookup;
   assign unused_lookup = ^lookup_reg;
   assign lookup_hit    = 1'b0;
   assign lookup_data   = '0;
`endif

endmodule
